// File: rtl/irs_block_manager_v4.sv
// IRS write-pointer / trigger-window manager: steers the write pointer around locked windows.
// Optional `IRS_BLOCK_DEADTIME_COUNTER_EN adds deadtime_o (cycles spent in SKIP).
module irs_block_manager_v4 #(
    parameter int unsigned PRETRIG_BLOCKS = 8,
    parameter int unsigned WINDOW_BLOCKS  = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wr_phase_i,
    input  logic       wr_ack_i,
    output logic [8:0] block_o,
    output logic       enable_o,
    input  logic       trig_i,
    output logic       evt_valid_o,
    output logic [8:0] evt_block_o,
    input  logic       evt_done_i,
    output logic [7:0] trig_dropped_o,
    output logic [2:0] state_o
`ifdef IRS_BLOCK_DEADTIME_COUNTER_EN
    ,
    output logic [15:0] deadtime_o
`endif
);

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_ALIGN = 3'd1,
        S_ARM   = 3'd2,
        S_RUN   = 3'd3,
        S_POST  = 3'd4,
        S_SKIP  = 3'd5
    } state_t;

    localparam logic [8:0] WIN9    = 9'(WINDOW_BLOCKS);
    localparam logic [8:0] PRE9    = 9'(PRETRIG_BLOCKS);
    localparam logic [8:0] POSTLEN = 9'(WINDOW_BLOCKS - PRETRIG_BLOCKS);

    state_t          state, ret_state, mode_nxt;
    logic [8:0]      ptr, start, postcnt;
    logic [3:0][8:0] slot;
    logic [3:0]      slot_vld;
    logic [1:0]      rd_idx, wr_idx;
    logic [7:0]      drop_cnt;
    logic [8:0]      ack_next, jmp_ack, jmp_cur;
    logic            hit_ack, hit_cur;
    logic            running, ack_eff, fifo_full, trig_ok, trig_drop, push, pop;

    // Compare both the post-ack pointer (RUN/POST) and the current pointer (SKIP) to all locked slots
    always_comb begin
        ack_next = ptr + 9'd1;
        hit_ack  = 1'b0;
        jmp_ack  = ack_next;
        hit_cur  = 1'b0;
        jmp_cur  = ptr;
        for (int unsigned i = 0; i < 4; i++) begin
            if (slot_vld[i[1:0]] && slot[i[1:0]] == ack_next) begin
                hit_ack = 1'b1;
                jmp_ack = slot[i[1:0]] + WIN9;
            end
            if (slot_vld[i[1:0]] && slot[i[1:0]] == ptr) begin
                hit_cur = 1'b1;
                jmp_cur = slot[i[1:0]] + WIN9;
            end
        end
    end

    always_comb begin
        running   = (state == S_RUN) || (state == S_POST);
        ack_eff   = wr_ack_i && running;
        fifo_full = &slot_vld;
        trig_ok   = trig_i && (state == S_RUN) && !fifo_full;
        trig_drop = trig_i && ((state == S_POST) || (state == S_SKIP) ||
                               ((state == S_RUN) && fifo_full));
        push      = ack_eff && (state == S_POST) && (postcnt == 9'd1);
        pop       = evt_done_i && slot_vld[rd_idx];
        mode_nxt  = state;
        if (trig_ok)
            mode_nxt = S_POST;
        else if (push)
            mode_nxt = S_RUN;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_RESET;
            ret_state <= S_RUN;
            ptr       <= '0;
            start     <= '0;
            postcnt   <= '0;
            slot      <= '0;
            slot_vld  <= '0;
            rd_idx    <= '0;
            wr_idx    <= '0;
            drop_cnt  <= '0;
        end else begin
            case (state)
                S_RESET: state <= S_ALIGN;
                S_ALIGN: if (wr_phase_i) state <= S_ARM;
                S_ARM: begin
                    if (!wr_phase_i) begin
                        state <= S_RUN;
                        ptr   <= '0;
                    end
                end
                S_RUN, S_POST: begin
                    if (trig_ok) begin
                        start   <= (ptr - PRE9) & 9'h1FE;
                        postcnt <= POSTLEN;
                    end
                    if (ack_eff) begin
                        if (state == S_POST)
                            postcnt <= postcnt - 9'd1;
                        if (hit_ack) begin
                            ptr       <= jmp_ack;
                            ret_state <= mode_nxt;
                            state     <= S_SKIP;
                        end else begin
                            ptr   <= ack_next;
                            state <= mode_nxt;
                        end
                    end else begin
                        state <= mode_nxt;
                    end
                end
                S_SKIP: begin
                    if (hit_cur)
                        ptr <= jmp_cur;
                    state <= ret_state;
                end
                default: state <= S_RESET;
            endcase

            // Push and pop never target the same entry: full blocks push, empty blocks pop
            if (push) begin
                slot[wr_idx]     <= start;
                slot_vld[wr_idx] <= 1'b1;
                wr_idx           <= wr_idx + 2'd1;
            end
            if (pop) begin
                slot_vld[rd_idx] <= 1'b0;
                rd_idx           <= rd_idx + 2'd1;
            end
            if (trig_drop && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

`ifdef IRS_BLOCK_DEADTIME_COUNTER_EN
    logic [15:0] dead_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || evt_done_i)
            dead_cnt <= '0;
        else if (state == S_SKIP && dead_cnt != 16'hFFFF)
            dead_cnt <= dead_cnt + 16'd1;
    end

    assign deadtime_o = dead_cnt;
`endif

    assign block_o        = ptr;
    assign enable_o       = running && (ptr[0] == wr_phase_i);
    assign evt_valid_o    = slot_vld[rd_idx];
    assign evt_block_o    = slot_vld[rd_idx] ? slot[rd_idx] : '0;
    assign trig_dropped_o = drop_cnt;
    assign state_o        = state;

endmodule

// File: tb/tb_irs_block_manager_v4.sv
// Scoreboard bench for irs_block_manager_v4: queue-based window model, directed scenarios then random traffic.
module tb_irs_block_manager_v4;
    localparam int P = 8;
    localparam int W = 16;
    localparam int M_RESET = 0, M_ALIGN = 1, M_ARM = 2, M_RUN = 3, M_POST = 4, M_SKIP = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1, ph = 1'b0, ack = 1'b0, trig = 1'b0, done = 1'b0;
    logic [8:0] block, evt_block;
    logic       enable, evt_valid;
    logic [7:0] dropped;
    logic [2:0] state;
`ifdef IRS_BLOCK_DEADTIME_COUNTER_EN
    logic [15:0] deadtime;
`endif

    always #5 clk = ~clk;

    irs_block_manager_v4 #(.PRETRIG_BLOCKS(P), .WINDOW_BLOCKS(W)) dut (
        .clk_i(clk), .rst_i(rst), .wr_phase_i(ph), .wr_ack_i(ack),
        .block_o(block), .enable_o(enable), .trig_i(trig),
        .evt_valid_o(evt_valid), .evt_block_o(evt_block), .evt_done_i(done),
        .trig_dropped_o(dropped), .state_o(state)
`ifdef IRS_BLOCK_DEADTIME_COUNTER_EN
        , .deadtime_o(deadtime)
`endif
    );

    typedef struct {
        int blk; int en; int ev; int eb; int dr; int st; int dt;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0, errors = 0;

    // Reference model: locked windows are just a queue of start blocks
    int m_mode = M_RESET, m_ret = M_RUN, m_ptr = 0, m_start = 0, m_post = 0, m_drop = 0, m_dead = 0;
    int m_q[$];

    function automatic int win_jump(int a);
        int r = -1;
        foreach (m_q[i]) if (m_q[i] == a) r = (m_q[i] + W) % 512;
        return r;
    endfunction

    task automatic model_step(input bit r, input bit p, input bit a, input bit t, input bit d);
        int nm, j, pre_n;
        bit do_push = 0;
        if (r) begin
            m_mode = M_RESET; m_ret = M_RUN; m_ptr = 0; m_start = 0; m_post = 0;
            m_drop = 0; m_dead = 0; m_q.delete();
            return;
        end
        pre_n = m_q.size();
        if (d) m_dead = 0;
        else if (m_mode == M_SKIP && m_dead < 65535) m_dead++;
        case (m_mode)
            M_RESET: m_mode = M_ALIGN;
            M_ALIGN: if (p) m_mode = M_ARM;
            M_ARM: if (!p) begin m_mode = M_RUN; m_ptr = 0; end
            M_RUN, M_POST: begin
                nm = m_mode;
                if (t) begin
                    if (m_mode == M_RUN && pre_n < 4) begin
                        m_start = ((m_ptr - P + 512) % 512) & 510;
                        m_post = W - P;
                        nm = M_POST;
                    end else if (m_drop < 255) m_drop++;
                end
                if (a) begin
                    if (m_mode == M_POST) begin
                        m_post--;
                        if (m_post == 0) begin do_push = 1; nm = M_RUN; end
                    end
                    j = win_jump((m_ptr + 1) % 512);
                    if (j >= 0) begin m_ptr = j; m_ret = nm; nm = M_SKIP; end
                    else m_ptr = (m_ptr + 1) % 512;
                end
                m_mode = nm;
            end
            M_SKIP: begin
                if (t && m_drop < 255) m_drop++;
                j = win_jump(m_ptr);
                if (j >= 0) m_ptr = j;
                m_mode = m_ret;
            end
            default: m_mode = M_RESET;
        endcase
        if (d && pre_n > 0) void'(m_q.pop_front());
        if (do_push) m_q.push_back(m_start);
    endtask

    task automatic cyc(input bit r, input bit p, input bit a, input bit t, input bit d);
        exp_t e;
        @(negedge clk);
        rst = r; ph = p; ack = a; trig = t; done = d;
        model_step(r, p, a, t, d);
        e.blk = m_ptr;
        e.en  = ((m_mode == M_RUN || m_mode == M_POST) && (m_ptr % 2) == int'(p)) ? 1 : 0;
        e.ev  = (m_q.size() > 0) ? 1 : 0;
        e.eb  = (m_q.size() > 0) ? m_q[0] : 0;
        e.dr  = m_drop;
        e.st  = m_mode;
        e.dt  = m_dead;
        exp_q.push_back(e);
    endtask

    task automatic ack1();
        cyc(0, m_ptr[0], 1, 0, 0);
    endtask

    task automatic walk_to(input int target);
        int n = 0;
        while (m_ptr != target && n < 2000) begin ack1(); n++; end
        if (m_ptr != target) begin
            errors++;
            $display("FAIL walk_to timeout: ptr=%0h required %0h", m_ptr, target);
        end
    endtask

    task automatic until_run();
        int n = 0;
        while (m_mode != M_RUN && n < 200) begin ack1(); n++; end
        if (m_mode != M_RUN) begin
            errors++;
            $display("FAIL until_run timeout: mode=%0d required %0d", m_mode, M_RUN);
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("block_o", int'(block), e.blk);
                chk("enable_o", int'(enable), e.en);
                chk("evt_valid_o", int'(evt_valid), e.ev);
                chk("evt_block_o", int'(evt_block), e.eb);
                chk("trig_dropped_o", int'(dropped), e.dr);
                chk("state_o", int'(state), e.st);
`ifdef IRS_BLOCK_DEADTIME_COUNTER_EN
                chk("deadtime_o", int'(deadtime), e.dt);
`endif
            end
        end
    end

    initial begin
        int n;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        // Align to phase and start at block 0
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // Window at 0x004, then write pointer wraps around into it
        walk_to(9'h00C);
        cyc(0, 0, 0, 1, 0);
        repeat (8) ack1();
        walk_to(9'h003);
        ack1();
        cyc(0, 0, 0, 0, 0);
        // Free it, then trigger near zero so the window wraps
        cyc(0, 0, 0, 0, 1);
        walk_to(9'h002);
        cyc(0, 0, 0, 1, 0);
        until_run();
        // Fill the FIFO, force a drop, free one, re-trigger, drop during POST
        n = 0;
        while (!(m_q.size() == 4 && m_mode == M_RUN) && n < 500) begin
            if (m_mode == M_RUN && m_q.size() < 4) cyc(0, 0, 0, 1, 0);
            else ack1();
            n++;
        end
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        // Reset while in POST with windows queued
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // Saturate the drop counter
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        repeat (300) cyc(0, $urandom_range(0, 1), 0, 1, 0);
        // Random traffic
        repeat (3000) begin
            cyc(($urandom_range(0, 999) == 0),
                $urandom_range(0, 1),
                ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 29) == 0),
                ($urandom_range(0, 39) == 0));
        end
        cyc(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d left required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/irs_block_manager_v4.md
IRS_BLOCK_MANAGER_V4 -- requirements
Module: irs_block_manager_v4

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter PRETRIG_BLOCKS, default 8: even number of blocks kept before a trigger.
REQ-003 Parameter WINDOW_BLOCKS, default 16: even number of blocks in a locked window; WINDOW_BLOCKS > PRETRIG_BLOCKS.
REQ-004 Port clk_i  input  1  system clock (1/32 sampling speed).
REQ-005 Port rst_i  input  1  synchronous active-high reset.
REQ-006 Port wr_phase_i  input  1  1 = write controller needs a high-cell (odd) block; 0 = low-cell (even) block.
REQ-007 Port wr_ack_i  input  1  one-cycle pulse; the presented block has been written.
REQ-008 Port block_o  output  9  block number presented to the write controller.
REQ-009 Port enable_o  output  1  block_o is valid for the current phase; request write.
REQ-010 Port trig_i  input  1  trigger pulse.
REQ-011 Port evt_valid_o  output  1  oldest locked window is available for readout.
REQ-012 Port evt_block_o  output  9  first block of the oldest locked window.
REQ-013 Port evt_done_i  input  1  one-cycle pulse; frees the oldest locked window.
REQ-014 Port trig_dropped_o  output  8  saturating count of dropped triggers.
REQ-015 Port state_o  output  3  debug copy of the FSM state.

Function
REQ-016 States: RESET, ALIGN, ARM, RUN, POST, SKIP.
- RESET->ALIGN unconditionally.
- ALIGN->ARM when wr_phase_i=1.
- ARM->RUN when wr_phase_i=0, with ptr=0.
REQ-017 block_o SHALL equal the 9-bit write pointer ptr; bit 0 of ptr is the cell half.
REQ-018 enable_o SHALL be combinational: (state RUN or POST) and (ptr[0]==wr_phase_i).
REQ-019 On wr_ack_i in RUN/POST, next = ptr+1 mod 512. If next equals the start of any active FIFO slot, ptr <= start+WINDOW_BLOCKS mod 512 and the FSM enters SKIP for one cycle. Otherwise ptr <= next.
REQ-020 SKIP SHALL repeat the slot check on ptr, jump again if it matches, then return to the prior state (RUN or POST). enable_o SHALL be 0 in SKIP; wr_ack_i in SKIP SHALL be ignored.
REQ-021 trig_i in RUN with FIFO not full:
- latch start = (ptr - PRETRIG_BLOCKS) mod 512 with bit 0 cleared, using the pre-ack ptr if wr_ack_i is simultaneous;
- load postcnt = WINDOW_BLOCKS - PRETRIG_BLOCKS;
- enter POST.
REQ-022 In POST each wr_ack_i SHALL decrement postcnt. When it reaches 0, start SHALL be pushed into the FIFO as an active slot and the FSM returns to RUN.
REQ-023 trig_i in POST or SKIP, or with the FIFO full (4 slots), SHALL be dropped and increment trig_dropped_o, saturating at 255.
REQ-024 Event FIFO: 4 entries, in-order. evt_valid_o = not empty; evt_block_o = head.
- evt_done_i with the FIFO empty SHALL be ignored.
- A simultaneous push and evt_done_i SHALL both take effect.
REQ-025 All pointer arithmetic SHALL be 9-bit modulo 512. A window may wrap past 511.

Reset
REQ-026 On rst_i (including mid-operation), outputs SHALL take these values next cycle: state RESET, ptr=0, block_o=0, enable_o=0, FIFO emptied (evt_valid_o=0, evt_block_o=0), postcnt=0, trig_dropped_o=0.
REQ-027 After rst_i deasserts, enable_o SHALL stay 0 until ARM->RUN.

Configuration
REQ-028 Macro IRS_BLOCK_DEADTIME_COUNTER_EN.
- When defined: adds output deadtime_o [15:0], a saturating count of cycles in RUN/POST/SKIP where enable_o=0 because state is SKIP, cleared by rst_i and by evt_done_i.
- When undefined: no port and no counter; all other behaviour is identical.

Verification
REQ-029 Reset, then wr_phase_i 1 then 0 -> RUN, block_o=0x000, enable_o=1; wr_ack_i -> block_o=0x001; enable_o=1 only while wr_phase_i=1.
REQ-030 Ack to ptr=0x0C; trig_i -> start=0x004; after 8 acks evt_valid_o=1, evt_block_o=0x004, state RUN, block_o=0x014.
REQ-031 With the window at 0x004 active, ack up to ptr=0x003 (after wrap) -> next ack gives SKIP, block_o=0x014, enable_o=0 for one cycle.
REQ-032 Trigger at ptr=0x002 -> start=0x1FA (wrap); the push gives evt_block_o=0x1FA.
REQ-033 Fill 4 windows, then trig_i -> trig_dropped_o=1; evt_done_i -> a trigger is accepted again. trig_i during POST -> counter increments.
REQ-034 rst_i asserted in POST with 2 windows queued -> next cycle evt_valid_o=0, enable_o=0, block_o=0, state RESET.
